// File: rtl/led_blink_driver.sv
// led_blink_driver: turns a one-shot blink request (N pulses) into a timed
// LED pattern of N on/off pulses. Each pulse is ON_CYCLES high followed by
// OFF_CYCLES low. The final low phase always runs, so back-to-back requests
// are always separated by a visible gap.
// Requests use a valid/ready handshake. led, busy and req_ready all come
// straight from flops.
//
// Optional feature macro: LED_BLINK_QUEUE_EN
//   Defined     : adds a one-entry holding register, so a second request can
//                 be accepted while a pattern runs. req_ready = ~queue_full.
//   Not defined : no holding register. req_ready is high only in IDLE.

module led_blink_driver #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 25_000_000,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic             busy,
  output logic             led
);

  // Timer must hold the longer of the two phase lengths.
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  // The timer is reloaded with (length - 1). A phase then lasts exactly
  // `length` cycles, with the exit decision taken while timer == 0.
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t             state_reg,  state_next;
  logic [TMR_W-1:0]   timer_reg,  timer_next;
  logic [CNT_W-1:0]   pulses_reg, pulses_next;
  logic               led_reg,    led_next;
  logic               busy_reg,   busy_next;
  logic               ready_reg,  ready_next;

  logic accept;
  logic start_valid;
  logic phase_done;
  logic final_end;

`ifdef LED_BLINK_QUEUE_EN
  logic               q_full_reg,  q_full_next;
  logic [CNT_W-1:0]   q_count_reg, q_count_next;
  logic               direct_start;
`endif

  // The handshake completes on the registered ready. A zero-count request
  // is consumed but never starts or queues a pattern.
  assign accept      = req_valid && ready_reg;
  assign start_valid = accept && (req_count != '0);
  assign phase_done  = (timer_reg == '0);
  assign final_end   = (state_reg == ST_OFF) && phase_done && (pulses_reg == '0);

  // Next-state, timer, pulse counter and registered-output computation.
  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    pulses_next = pulses_reg;
`ifdef LED_BLINK_QUEUE_EN
    q_full_next  = q_full_reg;
    q_count_next = q_count_reg;
    direct_start = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start_valid) begin
          state_next  = ST_ON;
          timer_next  = ON_LOAD;
          pulses_next = req_count;
`ifdef LED_BLINK_QUEUE_EN
          direct_start = 1'b1;
`endif
        end
      end

      ST_ON: begin
        if (phase_done) begin
          // One pulse's high phase is finished, so count it off here.
          state_next  = ST_OFF;
          timer_next  = OFF_LOAD;
          pulses_next = pulses_reg - CNT_W'(1);
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end

      ST_OFF: begin
        if (phase_done) begin
          if (pulses_reg != '0) begin
            state_next = ST_ON;
            timer_next = ON_LOAD;
          end else begin
`ifdef LED_BLINK_QUEUE_EN
            // Chain the next pattern with no IDLE cycle: a held request
            // takes priority, then a request arriving on this very edge.
            if (q_full_reg) begin
              state_next  = ST_ON;
              timer_next  = ON_LOAD;
              pulses_next = q_count_reg;
              q_full_next = 1'b0;
            end else if (start_valid) begin
              state_next   = ST_ON;
              timer_next   = ON_LOAD;
              pulses_next  = req_count;
              direct_start = 1'b1;
            end else begin
              state_next = ST_IDLE;
            end
`else
            state_next = ST_IDLE;
`endif
          end
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end

      default: begin
        state_next  = ST_IDLE;
        timer_next  = '0;
        pulses_next = '0;
      end
    endcase

`ifdef LED_BLINK_QUEUE_EN
    // A nonzero request that did not start a pattern directly is held. It
    // can only arrive while the holding register is empty, because
    // req_ready is low whenever the register is full.
    if (start_valid && !direct_start) begin
      q_full_next  = 1'b1;
      q_count_next = req_count;
    end
`endif

    // Outputs are computed from the next state, so each flop shows the
    // state that the same edge enters.
    led_next  = (state_next == ST_ON);
    busy_next = (state_next != ST_IDLE);
`ifdef LED_BLINK_QUEUE_EN
    ready_next = ~q_full_next;
`else
    ready_next = (state_next == ST_IDLE);
`endif
  end

  // State and output registers. Asynchronous reset drops the LED at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      pulses_reg <= '0;
      led_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      pulses_reg <= pulses_next;
      led_reg    <= led_next;
      busy_reg   <= busy_next;
      ready_reg  <= ready_next;
    end
  end

`ifdef LED_BLINK_QUEUE_EN
  // One-entry request holding register. Any held request is lost on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_full_reg  <= 1'b0;
      q_count_reg <= '0;
    end else begin
      q_full_reg  <= q_full_next;
      q_count_reg <= q_count_next;
    end
  end
`endif

  assign led       = led_reg;
  assign busy      = busy_reg;
  assign req_ready = ready_reg;

endmodule

// File: tb/tb_led_blink_driver.sv
// Testbench for led_blink_driver (ON=3, OFF=2, CNT_W=4).
// The stimulus side predicts, for every clock period, the expected
// (led, busy, req_ready) triple from the request rules and pushes it into
// a queue. A negedge monitor pops one entry per period and compares it
// against the DUT. An empty queue means the block should be idle.

module tb_led_blink_driver;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int CW  = 4;
`ifdef LED_BLINK_QUEUE_EN
  localparam logic PAT_READY = 1'b1;
`else
  localparam logic PAT_READY = 1'b0;
`endif

  typedef struct packed {
    logic led;
    logic busy;
    logic ready;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [CW-1:0] req_count;
  logic          req_ready;
  logic          busy;
  logic          led;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b1;

  led_blink_driver #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_count(req_count),
    .req_ready(req_ready),
    .busy     (busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s period %0d: got %0b expected %0b", name, cyc, act, exp);
  endtask

  // Monitor: one expected triple per clock period.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.led   = 1'b0;
        e.busy  = 1'b0;
        e.ready = 1'b1;
      end
      check("led",       led,       e.led);
      check("busy",      busy,      e.busy);
      check("req_ready", req_ready, e.ready);
    end
  end

  // Drive one period of stimulus. If the model expects the request to be
  // accepted at the next edge, append the resulting pattern.
  task automatic drive(input logic v, input logic [CW-1:0] n);
    logic exp_ready;
    exp_t e;
    @(posedge clk);
    #2;
    req_valid = v;
    req_count = n;
    exp_ready = (exp_q.size() > 0) ? exp_q[0].ready : 1'b1;
    if (v && exp_ready) begin
      $display("period %0d: request N=%0d accepted", cyc, n);
      if (n != 0) begin
        if (exp_q.size() == 0) begin
          e.led = 1'b0; e.busy = 1'b0; e.ready = 1'b1;
          exp_q.push_back(e);
        end
        // The request is held until the running pattern ends.
        for (int i = 1; i < exp_q.size(); i++) begin
          e = exp_q[i];
          e.ready = 1'b0;
          exp_q[i] = e;
        end
        for (int p = 0; p < int'(n); p++) begin
          for (int c = 0; c < ON; c++) begin
            e.led = 1'b1; e.busy = 1'b1; e.ready = PAT_READY;
            exp_q.push_back(e);
          end
          for (int c = 0; c < OFF; c++) begin
            e.led = 1'b0; e.busy = 1'b1; e.ready = PAT_READY;
            exp_q.push_back(e);
          end
        end
      end
    end else if (v) begin
      $display("period %0d: request N=%0d not accepted", cyc, n);
    end
  endtask

  // Idle until the predicted pattern has fully played out (bounded).
  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      drive(1'b0, '0);
      k++;
    end
    drive(1'b0, '0);
    chk_cnt++;
    if (exp_q.size() <= 1) pass_cnt++;
    else $display("FAIL drain_timeout period %0d: got %0d pending expected 0", cyc, exp_q.size());
  endtask

  initial begin
    req_valid = 1'b0;
    req_count = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    // Reset is held for two cycles; the monitor checks the idle state meanwhile.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) drive(1'b0, '0);

    // N=2 pattern.
    drive(1'b1, 4'd2);
    drain();

    // N=0 is consumed and does nothing.
    drive(1'b1, 4'd0);
    repeat (3) drive(1'b0, '0);

    // A second request arrives during a running pattern.
    drive(1'b1, 4'd2);
    repeat (3) drive(1'b0, '0);
    drive(1'b1, 4'd5);
    drain();

    // Maximum count.
    drive(1'b1, 4'd15);
    drain();

    // Asynchronous reset in the middle of an ON phase.
    drive(1'b1, 4'd3);
    drive(1'b0, '0);
    drive(1'b0, '0);
    #1;
    mon_en = 1'b0;
    check("led_before_rst", led, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_led_async",   led,       1'b0);
    check("rst_busy_async",  busy,      1'b0);
    check("rst_ready_async", req_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) drive(1'b0, '0);

    // Random requests.
    for (int i = 0; i < 400; i++) begin
      logic          v;
      logic [CW-1:0] n;
      v = ($urandom_range(0, 3) == 0);
      n = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 3));
      drive(v, n);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
